setn_stagger_ctrl: RTL and testbench

Sequencer that presets a bank of negative-edge, active-low-set flip-flops (dffnsnq family) one group at a time. Staggering the SETN assertions limits simultaneous switching current. The bank's clock is gated off for the whole preset window, so set and capture never overlap. The block sits between a power/init manager (REQ/ACK) and the SETN and clock-enable pins of the register bank; all outputs are registered, so SETN is glitch-free.

---
 rtl/setn_seq_pkg.sv | 29 ++
 rtl/setn_seq_pick.sv | 32 +++
 rtl/setn_stagger_ctrl.sv | 174 +++++++++++++++++
 tb/tb_setn_stagger_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/setn_seq_pkg.sv
// Shared types and sizing helpers for the SETN stagger sequencer.
package setn_seq_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GATE    = 3'd1,
      PULSE   = 3'd2,
      GAP     = 3'd3,
      RELEASE = 3'd4,
      DONE    = 3'd5
   } state_e;

   // Pulse/gap counter width: wide enough to hold max(PULSE_CYC, GAP_CYC)
   function automatic int unsigned cnt_width(input int unsigned pulse_cyc,
                                             input int unsigned gap_cyc);
      int unsigned m;
      int unsigned w;
      m = (pulse_cyc > gap_cyc) ? pulse_cyc : gap_cyc;
      w = $clog2(m + 1);
      return (w < 1) ? 1 : w;
   endfunction

   // Width of a group index
   function automatic int unsigned idx_width(input int unsigned ngroups);
      return (ngroups > 1) ? $clog2(ngroups) : 1;
   endfunction

endpackage

// File: rtl/setn_seq_pick.sv
// Priority picker: lowest set mask bit, either from bit 0 (first_i) or
// strictly above idx_i.
module setn_seq_pick #(
   parameter int unsigned NGROUPS = 4,
   parameter int unsigned IW      = 2
) (
   input  logic [NGROUPS-1:0] mask_i,
   input  logic [IW-1:0]      idx_i,
   input  logic               first_i,
   output logic [IW-1:0]      idx_o,
   output logic               found_o
);

   logic          found_c;
   logic [IW-1:0] idx_c;

   // Ascending scan keeps the first hit, giving the lowest qualifying bit
   always_comb begin
      found_c = 1'b0;
      idx_c   = '0;
      for (int i = 0; i < int'(NGROUPS); i++) begin
         if (!found_c && mask_i[i] && (first_i || (i > int'(idx_i)))) begin
            found_c = 1'b1;
            idx_c   = IW'(i);
         end
      end
   end

   assign idx_o   = idx_c;
   assign found_o = found_c;

endmodule

// File: rtl/setn_stagger_ctrl.sv
// Staggered SETN preset sequencer for a gated negative-edge flop bank.
// Optional feature macro: SETN_SEQ_ABORT_EN (adds abort_i, skips the
// remaining groups and closes the window through RELEASE/DONE).
module setn_stagger_ctrl
   import setn_seq_pkg::*;
#(
   parameter int unsigned NGROUPS   = 4,
   parameter int unsigned PULSE_CYC = 2,
   parameter int unsigned GAP_CYC   = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               req_i,
   input  logic [NGROUPS-1:0] grp_mask_i,
`ifdef SETN_SEQ_ABORT_EN
   input  logic               abort_i,
`endif
   output logic [NGROUPS-1:0] setn_o,
   output logic               clkn_en_o,
   output logic               busy_o,
   output logic               ack_o
);

   localparam int unsigned IW = idx_width(NGROUPS);
   localparam int unsigned CW = cnt_width(PULSE_CYC, GAP_CYC);
   localparam int unsigned GAP_LOAD_I = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
   localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYC - 1);
   localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_LOAD_I);

   state_e             state_q;
   logic [NGROUPS-1:0] mask_q;
   logic [IW-1:0]      idx_q;
   logic [CW-1:0]      cnt_q;
   logic [NGROUPS-1:0] setn_q;
   logic               clkn_en_q;
   logic               busy_q;
   logic               ack_q;

   logic [IW-1:0]      pick_idx_d;
   logic               pick_found_d;
   logic               abort_c;

`ifdef SETN_SEQ_ABORT_EN
   assign abort_c = abort_i;
`else
   assign abort_c = 1'b0;
`endif

   // Next group to pulse: lowest set bit in GATE, next higher bit otherwise
   setn_seq_pick #(
      .NGROUPS (NGROUPS),
      .IW      (IW)
   ) u_pick (
      .mask_i  (mask_q),
      .idx_i   (idx_q),
      .first_i (state_q == GATE),
      .idx_o   (pick_idx_d),
      .found_o (pick_found_d)
   );

   // All-ones vector with a single low bit at idx
   function automatic logic [NGROUPS-1:0] one_cold(input logic [IW-1:0] idx);
      logic [NGROUPS-1:0] v;
      v      = '1;
      v[idx] = 1'b0;
      return v;
   endfunction

   // Sequencer FSM with registered SETN, clock-gate, busy and ack outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         mask_q    <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         setn_q    <= '1;
         clkn_en_q <= 1'b1;
         busy_q    <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               ack_q <= 1'b0;
               if (req_i) begin
                  busy_q <= 1'b1;
                  if (|grp_mask_i) begin
                     mask_q    <= grp_mask_i;
                     clkn_en_q <= 1'b0;
                     state_q   <= GATE;
                  end else begin
                     ack_q   <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end

            GATE: begin
               if (abort_c) begin
                  state_q <= RELEASE;
               end else begin
                  idx_q   <= pick_idx_d;
                  setn_q  <= one_cold(pick_idx_d);
                  cnt_q   <= PULSE_LOAD;
                  state_q <= PULSE;
               end
            end

            PULSE: begin
               if (abort_c) begin
                  setn_q  <= '1;
                  state_q <= RELEASE;
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
               end else if (pick_found_d) begin
                  idx_q <= pick_idx_d;
                  if (GAP_CYC == 0) begin
                     setn_q  <= one_cold(pick_idx_d);
                     cnt_q   <= PULSE_LOAD;
                     state_q <= PULSE;
                  end else begin
                     setn_q  <= '1;
                     cnt_q   <= GAP_LOAD;
                     state_q <= GAP;
                  end
               end else begin
                  setn_q  <= '1;
                  state_q <= RELEASE;
               end
            end

            GAP: begin
               if (abort_c) begin
                  setn_q  <= '1;
                  state_q <= RELEASE;
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
               end else begin
                  setn_q  <= one_cold(idx_q);
                  cnt_q   <= PULSE_LOAD;
                  state_q <= PULSE;
               end
            end

            // SETN has been high for this whole cycle, so the clock may return
            RELEASE: begin
               setn_q    <= '1;
               clkn_en_q <= 1'b1;
               ack_q     <= 1'b1;
               state_q   <= DONE;
            end

            DONE: begin
               ack_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end

            default: begin
               setn_q    <= '1;
               clkn_en_q <= 1'b1;
               busy_q    <= 1'b0;
               ack_q     <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign setn_o    = setn_q;
   assign clkn_en_o = clkn_en_q;
   assign busy_o    = busy_q;
   assign ack_o     = ack_q;

endmodule

// File: tb/tb_setn_stagger_ctrl.sv
// Bench for setn_stagger_ctrl: two instances (GAP_CYC=1 and GAP_CYC=0)
// share stimulus and are compared every cycle against a schedule-based model.
module tb_setn_stagger_ctrl;

   localparam int NG    = 4;
   localparam int PULSE = 2;
`ifdef SETN_SEQ_ABORT_EN
   localparam bit ABORT_ON = 1'b1;
`else
   localparam bit ABORT_ON = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          req;
   logic          abort;
   logic [NG-1:0] mask;

   logic [NG-1:0] setn_a, setn_b;
   logic          clkn_a, clkn_b;
   logic          busy_a, busy_b;
   logic          ack_a, ack_b;

   setn_stagger_ctrl #(.NGROUPS(NG), .PULSE_CYC(PULSE), .GAP_CYC(1)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_i      (req),
      .grp_mask_i (mask),
`ifdef SETN_SEQ_ABORT_EN
      .abort_i    (abort),
`endif
      .setn_o     (setn_a),
      .clkn_en_o  (clkn_a),
      .busy_o     (busy_a),
      .ack_o      (ack_a)
   );

   setn_stagger_ctrl #(.NGROUPS(NG), .PULSE_CYC(PULSE), .GAP_CYC(0)) dut_g0 (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_i      (req),
      .grp_mask_i (mask),
`ifdef SETN_SEQ_ABORT_EN
      .abort_i    (abort),
`endif
      .setn_o     (setn_b),
      .clkn_en_o  (clkn_b),
      .busy_o     (busy_b),
      .ack_o      (ack_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs for one cycle; abortable marks gate/pulse/gap cycles
   typedef struct packed {
      logic [NG-1:0] setn;
      logic          clkn;
      logic          busy;
      logic          ack;
      logic          abortable;
   } exp_t;

   exp_t sched [2][64];
   int   rd [2];
   int   wr [2];
   exp_t cur [2];

   int n_checks;
   int n_errors;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [NG-1:0] s, input logic c, input logic b,
                               input logic a, input logic ab);
      exp_t e;
      e.setn = s; e.clkn = c; e.busy = b; e.ack = a; e.abortable = ab;
      return e;
   endfunction

   function automatic void push(input int m, input exp_t e);
      sched[m][wr[m]] = e;
      wr[m]++;
   endfunction

   // Build the full output schedule of one accepted request
   function automatic void build(input int m, input logic [NG-1:0] mk_mask);
      int  gap;
      bit  first;
      logic [NG-1:0] lowv;
      gap   = (m == 0) ? 1 : 0;
      first = 1'b1;
      if (mk_mask == '0) begin
         push(m, mk('1, 1'b1, 1'b1, 1'b1, 1'b0));
         return;
      end
      push(m, mk('1, 1'b0, 1'b1, 1'b0, 1'b1));
      for (int g = 0; g < NG; g++) begin
         if (mk_mask[g]) begin
            if (!first)
               for (int k = 0; k < gap; k++) push(m, mk('1, 1'b0, 1'b1, 1'b0, 1'b1));
            lowv    = '1;
            lowv[g] = 1'b0;
            for (int k = 0; k < PULSE; k++) push(m, mk(lowv, 1'b0, 1'b1, 1'b0, 1'b1));
            first = 1'b0;
         end
      end
      push(m, mk('1, 1'b0, 1'b1, 1'b0, 1'b0));
      push(m, mk('1, 1'b1, 1'b1, 1'b1, 1'b0));
   endfunction

   // Advance the model by one clock edge using the inputs seen at that edge
   function automatic void model_step(input int m);
      if (rst) begin
         rd[m]  = 0;
         wr[m]  = 0;
         cur[m] = mk('1, 1'b1, 1'b0, 1'b0, 1'b0);
         return;
      end
      if (ABORT_ON && abort && cur[m].abortable) begin
         rd[m] = 0;
         wr[m] = 0;
         push(m, mk('1, 1'b0, 1'b1, 1'b0, 1'b0));
         push(m, mk('1, 1'b1, 1'b1, 1'b1, 1'b0));
      end else if (rd[m] == wr[m]) begin
         rd[m] = 0;
         wr[m] = 0;
         if (!cur[m].busy && req) build(m, mask);
      end
      if (rd[m] < wr[m]) begin
         cur[m] = sched[m][rd[m]];
         rd[m]++;
      end else begin
         cur[m] = mk('1, 1'b1, 1'b0, 1'b0, 1'b0);
      end
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check("setn_gap1", 32'(setn_a), 32'(cur[0].setn));
      check("clkn_gap1", 32'(clkn_a), 32'(cur[0].clkn));
      check("busy_gap1", 32'(busy_a), 32'(cur[0].busy));
      check("ack_gap1",  32'(ack_a),  32'(cur[0].ack));
      check("setn_gap0", 32'(setn_b), 32'(cur[1].setn));
      check("clkn_gap0", 32'(clkn_b), 32'(cur[1].clkn));
      check("busy_gap0", 32'(busy_b), 32'(cur[1].busy));
      check("ack_gap0",  32'(ack_b),  32'(cur[1].ack));
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      for (int m = 0; m < 2; m++) begin
         rd[m] = 0; wr[m] = 0;
         cur[m] = mk('1, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      rst = 1'b1; req = 1'b0; abort = 1'b0; mask = '0;
      idle_cycles(2);
      rst = 1'b0;
      idle_cycles(2);

      // Mask 0101, single-cycle request
      mask = 4'b0101; req = 1'b1;
      cycle();
      req = 1'b0; mask = 4'b1111;
      idle_cycles(14);

      // Empty mask: immediate ack, no gating
      mask = 4'b0000; req = 1'b1;
      cycle();
      req = 1'b0;
      idle_cycles(4);

      // All groups
      mask = 4'b1111; req = 1'b1;
      cycle();
      req = 1'b0;
      idle_cycles(16);

      // Request held high, mask changed after acceptance
      mask = 4'b1000; req = 1'b1;
      idle_cycles(3);
      mask = 4'b0001;
      idle_cycles(16);
      req = 1'b0;
      idle_cycles(8);

      // Reset in the middle of a pulse
      mask = 4'b0101; req = 1'b1;
      cycle();
      req = 1'b0;
      idle_cycles(2);
      rst = 1'b1;
      idle_cycles(2);
      rst = 1'b0;
      idle_cycles(3);

`ifdef SETN_SEQ_ABORT_EN
      // Abort in the first pulse cycle of group 0
      mask = 4'b0011; req = 1'b1;
      cycle();
      req = 1'b0;
      cycle();
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      idle_cycles(6);
`endif

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         rst   = ($urandom_range(0, 79) == 0);
         req   = ($urandom_range(0, 3) == 0);
         mask  = NG'($urandom);
         abort = ABORT_ON && ($urandom_range(0, 11) == 0);
         cycle();
      end
      rst = 1'b0; req = 1'b0; abort = 1'b0;
      idle_cycles(20);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
